// File: rtl/rob_multi_commit.sv
// Reorder buffer that retires up to COMMIT_W ready entries per cycle in
// program order and flushes only on a mispredicted JUMP/BOTH entry.
//
// Ports:
//   clk_in, rst_in, rdy_in        clock, sync active-high reset, global enable
//   from_decoder / to_decoder_tag allocate at tail / tag of next allocation
//   from_rs_*                     RS writeback (op, rd, data, redirect, mispred)
//   from_lsb_*                    load data writeback
//   clear, to_if_pc               flush pulse and redirect PC
//   to_if_bsy, to_rs, free_cnt    issue-room flags and free entry count
//   to_reg_file*                  per-slot register write port
//   to_rs_update*                 per-slot operand broadcast
//   to_lsb, to_lsb_tag            store commit pulse and tag
module rob_multi_commit #(
    parameter int ROB_WIDTH   = 4,
    parameter int ROB_SIZE    = 2 ** ROB_WIDTH,
    parameter int COMMIT_W    = 2,
    parameter int AFULL_SLACK = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            from_decoder,
    output logic [ROB_WIDTH-1:0]            to_decoder_tag,
    input  logic                            from_rs,
    input  logic [ROB_WIDTH-1:0]            from_rs_tag,
    input  logic [2:0]                      from_rs_op,
    input  logic [4:0]                      from_rs_rd,
    input  logic [31:0]                     from_rs_wdata,
    input  logic [31:0]                     from_rs_jump,
    input  logic                            from_rs_mispred,
    input  logic                            from_lsb,
    input  logic [ROB_WIDTH-1:0]            from_lsb_tag,
    input  logic [31:0]                     from_lsb_wdata,
    output logic                            clear,
    output logic [31:0]                     to_if_pc,
    output logic                            to_if_bsy,
    output logic                            to_rs,
    output logic [ROB_WIDTH:0]              free_cnt,
    output logic [COMMIT_W-1:0]             to_reg_file,
    output logic [5*COMMIT_W-1:0]           to_reg_file_rd,
    output logic [32*COMMIT_W-1:0]          to_reg_file_wdata,
    output logic [COMMIT_W-1:0]             to_rs_update,
    output logic [ROB_WIDTH*COMMIT_W-1:0]   to_rs_update_order,
    output logic [32*COMMIT_W-1:0]          to_rs_update_wdata,
    output logic                            to_lsb,
    output logic [ROB_WIDTH-1:0]            to_lsb_tag
);
    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_JUMP  = 3'd1;
    localparam logic [2:0] OP_BOTH  = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_STORE = 3'd4;

    typedef logic [ROB_WIDTH-1:0] ptr_t;
    typedef logic [ROB_WIDTH:0]   cnt_t;

    localparam cnt_t SIZE_C = cnt_t'(ROB_SIZE);
    localparam logic [ROB_WIDTH+1:0] SLACK_C = (ROB_WIDTH+2)'(AFULL_SLACK);

    ptr_t  head;
    ptr_t  tail;
    cnt_t  busy_cnt;

    logic [ROB_SIZE-1:0] rdy_q;
    logic [ROB_SIZE-1:0] mis_q;
    logic [2:0]          op_q    [ROB_SIZE];
    logic [4:0]          rd_q    [ROB_SIZE];
    logic [31:0]         wdata_q [ROB_SIZE];
    logic [31:0]         jump_q  [ROB_SIZE];

    cnt_t                          n_ret;
    ptr_t                          slot;
    logic                          stop;
    logic                          store_seen;
    logic                          flush_nx;
    logic [31:0]                   pc_nx;
    logic [COMMIT_W-1:0]           we_nx;
    logic [COMMIT_W-1:0]           upd_nx;
    logic [5*COMMIT_W-1:0]         rd_nx;
    logic [32*COMMIT_W-1:0]        wd_nx;
    logic [ROB_WIDTH*COMMIT_W-1:0] ord_nx;
    logic                          lsb_nx;
    ptr_t                          lsb_tag_nx;
    logic                          alloc_ok;
    cnt_t                          busy_nx;
    logic                          bsy_nx;

    assign to_decoder_tag = tail;

    // Scan uses start-of-cycle state only, so same-cycle writebacks
    // to the head are picked up on the following cycle.
    always_comb begin
        n_ret      = '0;
        slot       = '0;
        stop       = 1'b0;
        store_seen = 1'b0;
        flush_nx   = 1'b0;
        pc_nx      = to_if_pc;
        we_nx      = '0;
        upd_nx     = '0;
        rd_nx      = '0;
        wd_nx      = '0;
        ord_nx     = '0;
        lsb_nx     = 1'b0;
        lsb_tag_nx = to_lsb_tag;
        for (int i = 0; i < COMMIT_W; i++) begin
            slot = head + ptr_t'(i);
            if (!stop) begin
                if (cnt_t'(i) >= busy_cnt || !rdy_q[slot] ||
                    (op_q[slot] == OP_STORE && store_seen)) begin
                    stop = 1'b1;
                end else begin
                    n_ret = n_ret + cnt_t'(1);
                    unique case (op_q[slot])
                        OP_WRITE, OP_LOAD, OP_BOTH: begin
                            upd_nx[i] = 1'b1;
                            we_nx[i]  = (rd_q[slot] != 5'd0);
                            rd_nx[5*i +: 5]   = rd_q[slot];
                            wd_nx[32*i +: 32] = wdata_q[slot];
                            ord_nx[ROB_WIDTH*i +: ROB_WIDTH] = slot;
                        end
                        OP_STORE: begin
                            lsb_nx     = 1'b1;
                            lsb_tag_nx = slot;
                            store_seen = 1'b1;
                        end
                        default: ;
                    endcase
                    // A mispredicted branch retires itself but nothing younger.
                    if ((op_q[slot] == OP_JUMP || op_q[slot] == OP_BOTH) &&
                        mis_q[slot]) begin
                        flush_nx = 1'b1;
                        pc_nx    = jump_q[slot];
                        stop     = 1'b1;
                    end
                end
            end
        end
    end

    assign alloc_ok = from_decoder && (busy_cnt != SIZE_C);
    assign busy_nx  = busy_cnt - n_ret + cnt_t'(alloc_ok);
    assign bsy_nx   = ({1'b0, busy_nx} + SLACK_C) < {1'b0, SIZE_C};

    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (rst_in || clear) begin
                head               <= '0;
                tail               <= '0;
                busy_cnt           <= '0;
                rdy_q              <= '0;
                clear              <= 1'b0;
                to_if_bsy          <= 1'b1;
                to_rs              <= 1'b1;
                free_cnt           <= SIZE_C;
                to_reg_file        <= '0;
                to_reg_file_rd     <= '0;
                to_reg_file_wdata  <= '0;
                to_rs_update       <= '0;
                to_rs_update_order <= '0;
                to_rs_update_wdata <= '0;
                to_lsb             <= 1'b0;
                to_lsb_tag         <= '0;
                if (rst_in) begin
                    to_if_pc <= '0;
                end
            end else begin
                head     <= head + n_ret[ROB_WIDTH-1:0];
                busy_cnt <= busy_nx;
                if (alloc_ok) begin
                    rdy_q[tail] <= 1'b0;
                    tail        <= tail + ptr_t'(1);
                end
                if (from_rs) begin
                    op_q[from_rs_tag]    <= from_rs_op;
                    rd_q[from_rs_tag]    <= from_rs_rd;
                    wdata_q[from_rs_tag] <= from_rs_wdata;
                    jump_q[from_rs_tag]  <= from_rs_jump;
                    mis_q[from_rs_tag]   <= from_rs_mispred;
                    rdy_q[from_rs_tag]   <= (from_rs_op != OP_LOAD);
                end
                // Placed after the RS write so LSB data wins on a tag clash.
                if (from_lsb) begin
                    wdata_q[from_lsb_tag] <= from_lsb_wdata;
                    rdy_q[from_lsb_tag]   <= 1'b1;
                end
                clear              <= flush_nx;
                to_if_pc           <= pc_nx;
                free_cnt           <= SIZE_C - busy_nx;
                to_if_bsy          <= bsy_nx;
                to_rs              <= bsy_nx;
                to_reg_file        <= we_nx;
                to_reg_file_rd     <= rd_nx;
                to_reg_file_wdata  <= wd_nx;
                to_rs_update       <= upd_nx;
                to_rs_update_order <= ord_nx;
                to_rs_update_wdata <= wd_nx;
                to_lsb             <= lsb_nx;
                to_lsb_tag         <= lsb_tag_nx;
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Self-checking bench for rob_multi_commit: directed vector table,
// hand-written corner sequences and randomized traffic against a model.
module tb_rob_multi_commit;
    localparam int RW = 4;
    localparam int SZ = 16;
    localparam int W  = 2;

    localparam bit [2:0] OP_WRITE = 3'd0;
    localparam bit [2:0] OP_JUMP  = 3'd1;
    localparam bit [2:0] OP_BOTH  = 3'd2;
    localparam bit [2:0] OP_LOAD  = 3'd3;
    localparam bit [2:0] OP_STORE = 3'd4;

    logic              clk_in = 1'b0;
    logic              rst_in, rdy_in, from_decoder;
    logic [RW-1:0]     to_decoder_tag;
    logic              from_rs;
    logic [RW-1:0]     from_rs_tag;
    logic [2:0]        from_rs_op;
    logic [4:0]        from_rs_rd;
    logic [31:0]       from_rs_wdata, from_rs_jump;
    logic              from_rs_mispred, from_lsb;
    logic [RW-1:0]     from_lsb_tag;
    logic [31:0]       from_lsb_wdata;
    logic              clear;
    logic [31:0]       to_if_pc;
    logic              to_if_bsy, to_rs;
    logic [RW:0]       free_cnt;
    logic [W-1:0]      to_reg_file;
    logic [5*W-1:0]    to_reg_file_rd;
    logic [32*W-1:0]   to_reg_file_wdata;
    logic [W-1:0]      to_rs_update;
    logic [RW*W-1:0]   to_rs_update_order;
    logic [32*W-1:0]   to_rs_update_wdata;
    logic              to_lsb;
    logic [RW-1:0]     to_lsb_tag;

    rob_multi_commit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .from_decoder(from_decoder), .to_decoder_tag(to_decoder_tag),
        .from_rs(from_rs), .from_rs_tag(from_rs_tag),
        .from_rs_op(from_rs_op), .from_rs_rd(from_rs_rd),
        .from_rs_wdata(from_rs_wdata), .from_rs_jump(from_rs_jump),
        .from_rs_mispred(from_rs_mispred),
        .from_lsb(from_lsb), .from_lsb_tag(from_lsb_tag),
        .from_lsb_wdata(from_lsb_wdata),
        .clear(clear), .to_if_pc(to_if_pc),
        .to_if_bsy(to_if_bsy), .to_rs(to_rs), .free_cnt(free_cnt),
        .to_reg_file(to_reg_file), .to_reg_file_rd(to_reg_file_rd),
        .to_reg_file_wdata(to_reg_file_wdata),
        .to_rs_update(to_rs_update),
        .to_rs_update_order(to_rs_update_order),
        .to_rs_update_wdata(to_rs_update_wdata),
        .to_lsb(to_lsb), .to_lsb_tag(to_lsb_tag)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        rdy;
        bit        wb;
        bit [2:0]  op;
        bit [4:0]  rd;
        bit [31:0] wd;
        bit [31:0] jp;
        bit        mis;
    } ment_t;

    ment_t     ment [SZ];
    int        mq[$];
    int        mtail = 0;
    bit        e_clear = 0;
    bit [31:0] e_pc = 0;
    bit [W-1:0] e_rf = 0, e_upd = 0;
    bit [4:0]  e_rd [W];
    bit [31:0] e_wd [W];
    bit [RW-1:0] e_ord [W];
    bit        e_lsb = 0;
    bit [RW-1:0] e_ltag = 0;
    int        e_free = SZ;
    bit        e_bsy = 1;

    function automatic void model_step();
        int  start, n;
        bit  st_seen, fl;
        if (!rdy_in) return;
        if (rst_in || e_clear) begin
            mq.delete();
            mtail = 0;
            foreach (ment[k]) begin
                ment[k].rdy = 0;
                ment[k].wb  = 0;
            end
            e_clear = 0; e_lsb = 0; e_rf = 0; e_upd = 0;
            e_free = SZ; e_bsy = 1;
            if (rst_in) e_pc = 0;
            return;
        end
        start = mq.size(); n = 0; st_seen = 0; fl = 0;
        e_rf = 0; e_upd = 0; e_lsb = 0;
        for (int s = 0; s < W; s++) begin
            int t;
            if (s >= start) break;
            t = mq[s];
            if (!ment[t].rdy) break;
            if (ment[t].op == OP_STORE && st_seen) break;
            n++;
            if (ment[t].op inside {OP_WRITE, OP_LOAD, OP_BOTH}) begin
                e_upd[s] = 1;
                e_rf[s]  = (ment[t].rd != 0);
                e_rd[s]  = ment[t].rd;
                e_wd[s]  = ment[t].wd;
                e_ord[s] = RW'(t);
            end
            if (ment[t].op == OP_STORE) begin
                e_lsb = 1; e_ltag = RW'(t); st_seen = 1;
            end
            if (ment[t].op inside {OP_JUMP, OP_BOTH} && ment[t].mis) begin
                fl = 1; e_pc = ment[t].jp;
                break;
            end
        end
        e_clear = fl;
        repeat (n) void'(mq.pop_front());
        if (from_decoder && start < SZ) begin
            mq.push_back(mtail);
            ment[mtail].rdy = 0;
            ment[mtail].wb  = 0;
            mtail = (mtail + 1) % SZ;
        end
        if (from_rs) begin
            ment[from_rs_tag].op  = from_rs_op;
            ment[from_rs_tag].rd  = from_rs_rd;
            ment[from_rs_tag].wd  = from_rs_wdata;
            ment[from_rs_tag].jp  = from_rs_jump;
            ment[from_rs_tag].mis = from_rs_mispred;
            ment[from_rs_tag].rdy = (from_rs_op != OP_LOAD);
            ment[from_rs_tag].wb  = 1;
        end
        if (from_lsb) begin
            ment[from_lsb_tag].rdy = 1;
            ment[from_lsb_tag].wd  = from_lsb_wdata;
        end
        e_free = SZ - mq.size();
        e_bsy  = (mq.size() + 4 < SZ);
    endfunction

    task automatic compare_model();
        chk("m clear", 32'(clear), 32'(e_clear));
        chk("m pc", to_if_pc, e_pc);
        chk("m reg_we", 32'(to_reg_file), 32'(e_rf));
        chk("m rs_upd", 32'(to_rs_update), 32'(e_upd));
        chk("m lsb", 32'(to_lsb), 32'(e_lsb));
        if (e_lsb) chk("m lsb_tag", 32'(to_lsb_tag), 32'(e_ltag));
        chk("m free", 32'(free_cnt), 32'(e_free));
        chk("m bsy", 32'(to_if_bsy), 32'(e_bsy));
        chk("m to_rs", 32'(to_rs), 32'(e_bsy));
        chk("m dtag", 32'(to_decoder_tag), 32'(mtail));
        for (int s = 0; s < W; s++) begin
            if (e_upd[s]) begin
                chk("m rd", 32'(to_reg_file_rd[5*s +: 5]), 32'(e_rd[s]));
                chk("m rf_wd", to_reg_file_wdata[32*s +: 32], e_wd[s]);
                chk("m upd_wd", to_rs_update_wdata[32*s +: 32], e_wd[s]);
                chk("m order", 32'(to_rs_update_order[RW*s +: RW]), 32'(e_ord[s]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic idle();
        rdy_in = 1; rst_in = 0; from_decoder = 0;
        from_rs = 0; from_rs_tag = 0; from_rs_op = 0; from_rs_rd = 0;
        from_rs_wdata = 0; from_rs_jump = 0; from_rs_mispred = 0;
        from_lsb = 0; from_lsb_tag = 0; from_lsb_wdata = 0;
    endtask

    task automatic rs_wb(input int tag, input bit [2:0] op, input int rd,
                         input bit [31:0] wd);
        from_rs = 1; from_rs_tag = RW'(tag); from_rs_op = op;
        from_rs_rd = 5'(rd); from_rs_wdata = wd;
        from_rs_jump = 0; from_rs_mispred = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        bit rst; bit dec;
        bit rs; bit [RW-1:0] tag; bit [2:0] op; bit [4:0] rd;
        bit [31:0] wd; bit [31:0] jp; bit mis;
        bit lsb; bit [RW-1:0] ltag; bit [31:0] lwd;
    } in_t;

    typedef struct packed {
        bit [W-1:0] rf; bit [4:0] rd0; bit [31:0] wd0; bit [4:0] rd1;
        bit lsb; bit [RW-1:0] ltag; bit clr; bit [31:0] pc;
        bit [RW:0] free; bit [RW-1:0] dtag;
    } ex_t;

    typedef struct packed { in_t i; ex_t x; } vec_t;

    vec_t tbl[$];

    function automatic in_t vin(bit rst, bit dec);
        in_t v;
        v = '0; v.rst = rst; v.dec = dec;
        return v;
    endfunction

    function automatic in_t vrs(int tag, bit [2:0] op, int rd,
                                bit [31:0] wd, bit [31:0] jp, bit mis);
        in_t v;
        v = '0; v.rs = 1; v.tag = RW'(tag); v.op = op; v.rd = 5'(rd);
        v.wd = wd; v.jp = jp; v.mis = mis;
        return v;
    endfunction

    function automatic in_t vls(int tag, bit [31:0] wd);
        in_t v;
        v = '0; v.lsb = 1; v.ltag = RW'(tag); v.lwd = wd;
        return v;
    endfunction

    function automatic ex_t vx(bit [W-1:0] rf, int rd0, bit [31:0] wd0,
                               int rd1, bit lsb, int ltag, bit clr,
                               bit [31:0] pc, int free, int dtag);
        ex_t x;
        x.rf = rf; x.rd0 = 5'(rd0); x.wd0 = wd0; x.rd1 = 5'(rd1);
        x.lsb = lsb; x.ltag = RW'(ltag); x.clr = clr; x.pc = pc;
        x.free = (RW+1)'(free); x.dtag = RW'(dtag);
        return x;
    endfunction

    task automatic apply(input in_t v);
        rdy_in = 1; rst_in = v.rst; from_decoder = v.dec;
        from_rs = v.rs; from_rs_tag = v.tag; from_rs_op = v.op;
        from_rs_rd = v.rd; from_rs_wdata = v.wd; from_rs_jump = v.jp;
        from_rs_mispred = v.mis;
        from_lsb = v.lsb; from_lsb_tag = v.ltag; from_lsb_wdata = v.lwd;
    endtask

    task automatic check_row(input int k, input ex_t x);
        chk($sformatf("row%0d reg_we", k), 32'(to_reg_file), 32'(x.rf));
        if (x.rf[0]) begin
            chk($sformatf("row%0d rd0", k), 32'(to_reg_file_rd[4:0]), 32'(x.rd0));
            chk($sformatf("row%0d wd0", k), to_reg_file_wdata[31:0], x.wd0);
        end
        if (x.rf[1])
            chk($sformatf("row%0d rd1", k), 32'(to_reg_file_rd[9:5]), 32'(x.rd1));
        chk($sformatf("row%0d lsb", k), 32'(to_lsb), 32'(x.lsb));
        if (x.lsb)
            chk($sformatf("row%0d lsb_tag", k), 32'(to_lsb_tag), 32'(x.ltag));
        chk($sformatf("row%0d clear", k), 32'(clear), 32'(x.clr));
        chk($sformatf("row%0d pc", k), to_if_pc, x.pc);
        chk($sformatf("row%0d free", k), 32'(free_cnt), 32'(x.free));
        chk($sformatf("row%0d bsy", k), 32'(to_if_bsy), 32'd1);
        chk($sformatf("row%0d dtag", k), 32'(to_decoder_tag), 32'(x.dtag));
    endtask

    int cand[$];
    int lc[$];

    initial begin
        // burst of three writes retired two then one
        tbl.push_back({vin(1, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 16, 0)});
        tbl.push_back({vin(0, 1), vx(0, 0, 0, 0, 0, 0, 0, 0, 15, 1)});
        tbl.push_back({vin(0, 1), vx(0, 0, 0, 0, 0, 0, 0, 0, 14, 2)});
        tbl.push_back({vin(0, 1), vx(0, 0, 0, 0, 0, 0, 0, 0, 13, 3)});
        tbl.push_back({vrs(2, OP_WRITE, 7, 'h33, 0, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 13, 3)});
        tbl.push_back({vrs(1, OP_WRITE, 6, 'h22, 0, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 13, 3)});
        tbl.push_back({vrs(0, OP_WRITE, 5, 'h11, 0, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 13, 3)});
        tbl.push_back({vin(0, 0), vx(2'b11, 5, 'h11, 6, 0, 0, 0, 0, 15, 3)});
        tbl.push_back({vin(0, 0), vx(2'b01, 7, 'h33, 0, 0, 0, 0, 0, 16, 3)});
        tbl.push_back({vin(0, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 16, 3)});
        // two stores: one per cycle
        tbl.push_back({vin(1, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 16, 0)});
        tbl.push_back({vin(0, 1), vx(0, 0, 0, 0, 0, 0, 0, 0, 15, 1)});
        tbl.push_back({vin(0, 1), vx(0, 0, 0, 0, 0, 0, 0, 0, 14, 2)});
        tbl.push_back({vrs(1, OP_STORE, 0, 'hAB, 0, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 14, 2)});
        tbl.push_back({vrs(0, OP_STORE, 0, 'hCD, 0, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 14, 2)});
        tbl.push_back({vin(0, 0), vx(0, 0, 0, 0, 1, 0, 0, 0, 15, 2)});
        tbl.push_back({vin(0, 0), vx(0, 0, 0, 0, 1, 1, 0, 0, 16, 2)});
        tbl.push_back({vin(0, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 16, 2)});
        // mispredicted jump flushes, younger write blocked
        tbl.push_back({vin(1, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 16, 0)});
        tbl.push_back({vin(0, 1), vx(0, 0, 0, 0, 0, 0, 0, 0, 15, 1)});
        tbl.push_back({vin(0, 1), vx(0, 0, 0, 0, 0, 0, 0, 0, 14, 2)});
        tbl.push_back({vrs(1, OP_WRITE, 3, 'h44, 0, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 14, 2)});
        tbl.push_back({vrs(0, OP_JUMP, 0, 0, 'h100, 1), vx(0, 0, 0, 0, 0, 0, 0, 0, 14, 2)});
        tbl.push_back({vin(0, 0), vx(0, 0, 0, 0, 0, 0, 1, 'h100, 15, 2)});
        tbl.push_back({vin(0, 0), vx(0, 0, 0, 0, 0, 0, 0, 'h100, 16, 0)});
        // correctly predicted BOTH retires alongside a write
        tbl.push_back({vin(1, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 16, 0)});
        tbl.push_back({vin(0, 1), vx(0, 0, 0, 0, 0, 0, 0, 0, 15, 1)});
        tbl.push_back({vin(0, 1), vx(0, 0, 0, 0, 0, 0, 0, 0, 14, 2)});
        tbl.push_back({vrs(1, OP_WRITE, 2, 'h9, 0, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 14, 2)});
        tbl.push_back({vrs(0, OP_BOTH, 1, 'h8, 'h200, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 14, 2)});
        tbl.push_back({vin(0, 0), vx(2'b11, 1, 'h8, 2, 0, 0, 0, 0, 16, 2)});
        // load waits for LSB data
        tbl.push_back({vin(1, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 16, 0)});
        tbl.push_back({vin(0, 1), vx(0, 0, 0, 0, 0, 0, 0, 0, 15, 1)});
        tbl.push_back({vrs(0, OP_LOAD, 4, 0, 0, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 15, 1)});
        tbl.push_back({vin(0, 0), vx(0, 0, 0, 0, 0, 0, 0, 0, 15, 1)});
        tbl.push_back({vls(0, 'hDEAD), vx(0, 0, 0, 0, 0, 0, 0, 0, 15, 1)});
        tbl.push_back({vin(0, 0), vx(2'b01, 4, 'hDEAD, 0, 0, 0, 0, 0, 16, 1)});

        idle();
        foreach (tbl[k]) begin
            apply(tbl[k].i);
            tick();
            check_row(k, tbl[k].x);
        end

        // fill to the almost-full threshold, then retire one
        idle(); rst_in = 1; tick(); idle();
        for (int k = 0; k < 12; k++) begin
            from_decoder = 1; tick();
        end
        idle();
        chk("fill free", 32'(free_cnt), 32'd4);
        chk("fill bsy", 32'(to_if_bsy), 32'd0);
        chk("fill to_rs", 32'(to_rs), 32'd0);
        rs_wb(0, OP_WRITE, 9, 'h55); tick(); idle();
        tick();
        chk("drain bsy", 32'(to_if_bsy), 32'd1);
        chk("drain free", 32'(free_cnt), 32'd5);
        chk("drain we", 32'(to_reg_file), 32'd1);
        rdy_in = 0; tick();
        chk("freeze we", 32'(to_reg_file), 32'd1);
        chk("freeze upd", 32'(to_rs_update), 32'd1);
        rdy_in = 1; tick();
        chk("unfreeze we", 32'(to_reg_file), 32'd0);

        // 40 entries streamed through to wrap the pointers
        idle(); rst_in = 1; tick();
        for (int k = 0; k < 40; k++) begin
            idle(); from_decoder = 1;
            if (k > 0) rs_wb((k - 1) % SZ, OP_WRITE, (k % 31) + 1, 32'(k));
            tick();
        end
        idle(); rs_wb(39 % SZ, OP_WRITE, 3, 'h39); tick();
        idle(); repeat (3) tick();
        chk("wrap dtag", 32'(to_decoder_tag), 32'd8);
        chk("wrap free", 32'(free_cnt), 32'd16);

        // randomized traffic
        idle(); rst_in = 1; tick();
        for (int c = 0; c < 3000; c++) begin
            idle();
            rdy_in = ($urandom_range(15) != 0);
            rst_in = ($urandom_range(199) == 0);
            from_decoder = (mq.size() < SZ) && ($urandom_range(1) == 1);
            cand.delete();
            foreach (mq[k]) if (!ment[mq[k]].wb) cand.push_back(mq[k]);
            if (cand.size() > 0 && $urandom_range(2) != 0) begin
                from_rs = 1;
                from_rs_tag = RW'(cand[$urandom_range(cand.size() - 1)]);
                from_rs_op = 3'($urandom_range(5));
                from_rs_rd = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
                from_rs_wdata = $urandom;
                from_rs_jump = $urandom;
                from_rs_mispred = ($urandom_range(7) == 0);
            end
            lc.delete();
            foreach (mq[k])
                if (ment[mq[k]].wb && !ment[mq[k]].rdy) lc.push_back(mq[k]);
            if (lc.size() > 0 && $urandom_range(1) == 1) begin
                from_lsb = 1;
                from_lsb_tag = RW'(lc[$urandom_range(lc.size() - 1)]);
                from_lsb_wdata = $urandom;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
- Parametrised successor to the single-commit reorder buffer.
- Holds ROB_SIZE in-flight instructions in program order and accepts results from the RS and LSB writeback paths.
- Retires up to COMMIT_W ready entries per cycle, in order.
- Flushes the pipeline only on a mispredicted JUMP/BOTH entry, not on every jump.
- Sits between decoder/RS/LSB and reg file/IF; the op encoding matches the existing core: WRITE=0, JUMP=1, BOTH=2, LOAD=3, STORE=4, NOTHING=5.

Parameters:
- ROB_WIDTH, 4, tag width; ROB_SIZE = 2**ROB_WIDTH.
- ROB_SIZE, 16, entry count; must equal 2**ROB_WIDTH.
- COMMIT_W, 2, maximum retirements per cycle; legal range 1..4.
- AFULL_SLACK, 4, free entries that must remain for to_if_bsy/to_rs to stay 1.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global enable; when 0, no state or output changes
- from_decoder  input  1  allocate entry at tail
- to_decoder_tag  output  ROB_WIDTH  tag the next allocation receives (= tail)
- from_rs  input  1  RS result valid
- from_rs_tag  input  ROB_WIDTH  target entry
- from_rs_op  input  3  op class
- from_rs_rd  input  5  destination register
- from_rs_wdata  input  32  result / store-free data
- from_rs_jump  input  32  redirect PC
- from_rs_mispred  input  1  JUMP/BOTH only: prediction was wrong
- from_lsb  input  1  load data valid
- from_lsb_tag  input  ROB_WIDTH  target entry
- from_lsb_wdata  input  32  load data
- clear  output  1  one-cycle flush pulse
- to_if_pc  output  32  redirect PC, valid with clear
- to_if_bsy  output  1  1 = room to issue
- to_rs  output  1  same condition as to_if_bsy
- free_cnt  output  ROB_WIDTH+1  ROB_SIZE - occupancy
- to_reg_file  output  COMMIT_W  per-slot reg write enable
- to_reg_file_rd  output  5*COMMIT_W  slot i at bits [5i+4:5i]
- to_reg_file_wdata  output  32*COMMIT_W  slot i
- to_rs_update  output  COMMIT_W  per-slot operand broadcast
- to_rs_update_order  output  ROB_WIDTH*COMMIT_W  committed tag per slot
- to_rs_update_wdata  output  32*COMMIT_W  committed data per slot
- to_lsb  output  1  store commit pulse
- to_lsb_tag  output  ROB_WIDTH  committed store tag

Behaviour:
- Occupancy tracking:
  - busy_cnt is ROB_WIDTH+1 bits; it disambiguates full from empty.
  - Pointers wrap modulo ROB_SIZE.
- Reset (rst_in=1, or clear=1, sampled while rdy_in=1):
  - head=tail=busy_cnt=0; every ready bit cleared.
  - clear=0; to_lsb, to_reg_file, to_rs_update all 0; to_if_bsy=to_rs=1; free_cnt=ROB_SIZE; to_if_pc=0 (rst_in only).
  - All inputs are ignored in that cycle.
- Allocate: from_decoder=1 -> ready[tail]=0, tail+1, busy_cnt+1.
  - Allocation while busy_cnt==ROB_SIZE is ignored; the protocol forbids it.
- RS writeback:
  - Stores op/rd/wdata/jump/mispred into the tagged entry.
  - ready=1, except op LOAD, which stays 0 until LSB writeback.
- LSB writeback: ready=1 and wdata=from_lsb_wdata.
  - If RS and LSB target the same tag in the same cycle, LSB wdata and ready win.
- Commit scan, slot i=0..COMMIT_W-1, on entry head+i. The scan stops at the first slot where any of these holds:
  - i >= busy_cnt (start-of-cycle count);
  - the entry is not ready;
  - the entry is a second STORE in the same cycle;
  - the previous slot retired a flushing entry.
- Retired WRITE/LOAD/BOTH:
  - to_reg_file[i]=1 and to_rs_update[i]=1 with rd/wdata/tag.
  - If rd==0, to_reg_file[i]=0 but to_rs_update[i] is still 1.
- Retired STORE: to_lsb=1, to_lsb_tag=that tag. At most one per cycle.
- Retired JUMP/BOTH with mispred=1 is a flushing entry:
  - clear=1, to_if_pc=jump.
  - Younger slots that cycle do not retire.
- Retired JUMP/BOTH with mispred=0: no flush; BOTH still writes rd.
- Slot packing: slots above the last retired slot output enables of 0. head advances by the retire count n.
- Occupancy update:
  - busy_cnt_next = busy_cnt - n + from_decoder.
  - free_cnt = ROB_SIZE - busy_cnt_next, registered.
  - to_if_bsy = to_rs = (busy_cnt_next + AFULL_SLACK < ROB_SIZE), registered.
- Output timing:
  - All outputs are registered; commit outputs are valid the cycle after the entry was ready at head.
  - Single-cycle pulses (to_reg_file, to_rs_update, to_lsb, clear) drop to 0 the next cycle unless re-asserted.
- Same-cycle corner cases:
  - Writeback to the head entry in the same cycle is not visible to that cycle's scan; it retires next cycle.
  - Allocation and full retirement in the same cycle: busy_cnt is correct and wrap at ROB_SIZE-1 -> 0 holds.
- rdy_in=0: everything frozen, including pulses, which hold their value.

Test Plan:
- Reset, then 3 allocations (tags 0,1,2), RS writeback WRITE rd=5/6/7 data 0x11/0x22/0x33 in one burst -> cycle 1 commits tags 0,1 (to_reg_file=2'b11, rd 5,6); next cycle tag 2 (to_reg_file=2'b01); free_cnt returns to 16.
- Tags 0 (STORE) and 1 (STORE) both ready -> to_lsb=1, tag 0 in the first cycle; tag 1 in the next cycle.
- Tag 0 JUMP mispred=1 jump=0x100, tag 1 WRITE ready -> clear=1, to_if_pc=0x100, to_reg_file=0; next cycle head=tail=0, clear=0.
- Tag 0 BOTH mispred=0 rd=1 wdata=0x8, tag 1 WRITE rd=2 -> both retire in one cycle; no clear.
- Fill 12 entries with nothing ready -> to_if_bsy=to_rs=0, free_cnt=4; retire 1 -> to_if_bsy back to 1.
- Tag 0 LOAD: RS writeback leaves it not ready; LSB writeback 0xDEAD -> retires next cycle with wdata 0xDEAD. Also cycle 40 entries through to check pointer wrap.
